// File: rtl/pulse_hs_tx.sv
// pulse_hs_tx: source side of a 4-phase req/ack pulse-transfer handshake (clka domain).
// Local event pulses are queued in a saturating counter and launched one at a
// time as a level request; the far side's acknowledge is synchronised locally.
// Optional build macro: PULSE_HS_TX_TIMEOUT_EN adds a sticky handshake-stall flag.
module pulse_hs_tx #(
  parameter int CNT_W    = 4,
  parameter int SYNC_STG = 2
`ifdef PULSE_HS_TX_TIMEOUT_EN
  ,
  parameter int TO_W     = 8
`endif
) (
  input  logic             clka,
  input  logic             rstna,
  input  logic             a_pul,
  input  logic             err_clr,
  input  logic             ack_async,
  output logic             req,
  output logic             done_pul,
  output logic             busy,
  output logic [CNT_W-1:0] pend_cnt,
  output logic             ovf,
  output logic             timeout
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ACK_HI = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SYNC_STG-1:0] ack_sync;
  logic                ack_s;
  state_t              state;
  state_t              state_nxt;
  logic                req_nxt;
  logic                done_nxt;
  logic                launch;
  logic [CNT_W-1:0]    pend_nxt;
  logic                ovf_set;

  // Bring the far-domain acknowledge into clka through a plain flop chain.
  always_ff @(posedge clka or negedge rstna) begin
    if (!rstna) ack_sync <= '0;
    else        ack_sync <= {ack_sync[SYNC_STG-2:0], ack_async};
  end

  assign ack_s = ack_sync[SYNC_STG-1];

  // Handshake sequencing: launch only when the previous ack has fully dropped.
  always_comb begin
    state_nxt = state;
    req_nxt   = 1'b0;
    done_nxt  = 1'b0;
    launch    = 1'b0;
    case (state)
      IDLE: begin
        if ((pend_cnt != '0) && !ack_s) begin
          launch    = 1'b1;
          req_nxt   = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (ack_s) state_nxt = ACK_HI;
        else       req_nxt   = 1'b1;
      end
      ACK_HI: begin
        if (!ack_s) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, request level and completion pulse are all registered so req is glitch-free.
  always_ff @(posedge clka or negedge rstna) begin
    if (!rstna) begin
      state    <= IDLE;
      req      <= 1'b0;
      done_pul <= 1'b0;
    end else begin
      state    <= state_nxt;
      req      <= req_nxt;
      done_pul <= done_nxt;
    end
  end

  // Pending-event arithmetic: events add, launches subtract, full counter drops the event.
  always_comb begin
    pend_nxt = pend_cnt;
    ovf_set  = 1'b0;
    if (a_pul && !launch) begin
      if (pend_cnt == CNT_MAX) ovf_set  = 1'b1;
      else                     pend_nxt = pend_cnt + 1'b1;
    end else if (!a_pul && launch) begin
      pend_nxt = pend_cnt - 1'b1;
    end
  end

  // Pending counter and sticky overflow flag; a new overflow beats a clear.
  always_ff @(posedge clka or negedge rstna) begin
    if (!rstna) begin
      pend_cnt <= '0;
      ovf      <= 1'b0;
    end else begin
      pend_cnt <= pend_nxt;
      if (ovf_set)      ovf <= 1'b1;
      else if (err_clr) ovf <= 1'b0;
    end
  end

  assign busy = (state != IDLE) | (pend_cnt != '0);

`ifdef PULSE_HS_TX_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_MAX = '1;
  localparam logic [TO_W-1:0] TO_PRE = {{(TO_W-1){1'b1}}, 1'b0};

  logic [TO_W-1:0] to_cnt;
  logic            to_set;

  assign to_set = (state_nxt == state) && (state != IDLE) && (to_cnt == TO_PRE);

  // Measure time spent in one waiting state; flag a stall once it saturates, but keep waiting.
  always_ff @(posedge clka or negedge rstna) begin
    if (!rstna) begin
      to_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      if (state_nxt != state)                      to_cnt <= '0;
      else if ((state != IDLE) && (to_cnt != TO_MAX)) to_cnt <= to_cnt + 1'b1;
      if (to_set)       timeout <= 1'b1;
      else if (err_clr) timeout <= 1'b0;
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pulse_hs_tx.sv
// tb_pulse_hs_tx: randomized scoreboard bench for pulse_hs_tx with a far-side ack responder.
module tb_pulse_hs_tx;

  localparam int CNT_W    = 3;
  localparam int SYNC_STG = 2;
  localparam int TO_W     = 4;
  localparam int PEND_MAX = (1 << CNT_W) - 1;
  localparam int TO_LIMIT = (1 << TO_W) - 1;

  logic             clka      = 1'b0;
  logic             rstna     = 1'b0;
  logic             a_pul     = 1'b0;
  logic             err_clr   = 1'b0;
  logic             ack_async = 1'b0;
  logic             req;
  logic             done_pul;
  logic             busy;
  logic [CNT_W-1:0] pend_cnt;
  logic             ovf;
  logic             timeout;

  always #5 clka = ~clka;

  pulse_hs_tx #(
    .CNT_W   (CNT_W),
    .SYNC_STG(SYNC_STG)
`ifdef PULSE_HS_TX_TIMEOUT_EN
    ,
    .TO_W    (TO_W)
`endif
  ) dut (
    .clka     (clka),
    .rstna    (rstna),
    .a_pul    (a_pul),
    .err_clr  (err_clr),
    .ack_async(ack_async),
    .req      (req),
    .done_pul (done_pul),
    .busy     (busy),
    .pend_cnt (pend_cnt),
    .ovf      (ovf),
    .timeout  (timeout)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    int pend;
    int ovf;
  } done_rec_t;

  done_rec_t done_q[$];

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference model: transfer phase 0=idle, 1=waiting for ack high, 2=waiting for ack low.
  int m_phase    = 0;
  int m_pend     = 0;
  int m_wait     = 0;
  int m_ovf      = 0;
  int m_to       = 0;
  int m_req      = 0;
  int m_done     = 0;
  int m_launches = 0;
  bit ack_hist[$];

  // The model sees ack through the same number of clka samples as the design.
  always @(posedge clka or negedge rstna) begin
    if (!rstna) begin
      m_phase = 0; m_pend = 0; m_wait = 0; m_ovf = 0; m_to = 0;
      m_req = 0; m_done = 0;
      ack_hist.delete();
      for (int i = 0; i < SYNC_STG; i++) ack_hist.push_back(1'b0);
      done_q.delete();
    end else begin
      bit ack_s;
      bit launch;
      bit ovf_set;
      bit to_set;
      int nphase;
      ack_s = ack_hist[SYNC_STG-1];
      ack_hist.push_front(ack_async);
      void'(ack_hist.pop_back());
      launch  = (m_phase == 0) && (m_pend > 0) && !ack_s;
      ovf_set = 1'b0;
      to_set  = 1'b0;
      nphase  = m_phase;
      m_done  = 0;
      if (launch) nphase = 1;
      else if (m_phase == 1 && ack_s) nphase = 2;
      else if (m_phase == 2 && !ack_s) begin nphase = 0; m_done = 1; end
      if (launch) m_launches++;
      if (a_pul && !launch) begin
        if (m_pend == PEND_MAX) ovf_set = 1'b1;
        else m_pend++;
      end else if (!a_pul && launch) m_pend--;
`ifdef PULSE_HS_TX_TIMEOUT_EN
      if (nphase != m_phase) m_wait = 0;
      else if (m_phase != 0 && m_wait < TO_LIMIT) begin
        m_wait++;
        if (m_wait == TO_LIMIT) to_set = 1'b1;
      end
      if (to_set) m_to = 1;
      else if (err_clr) m_to = 0;
`endif
      if (ovf_set) m_ovf = 1;
      else if (err_clr) m_ovf = 0;
      m_phase = nphase;
      m_req   = (m_phase == 1);
      if (m_done) begin
        done_rec_t r;
        r.pend = m_pend;
        r.ovf  = m_ovf;
        done_q.push_back(r);
      end
    end
  end

  // Far-side responder: ack follows req after a short random delay; can be stalled or forced.
  bit stall     = 1'b0;
  bit force_ack = 1'b0;
  int dly       = 0;

  always @(negedge clka or negedge rstna) begin
    if (!rstna) begin
      ack_async = 1'b0;
      dly       = $urandom_range(0, 3);
    end else if (force_ack) ack_async = 1'b1;
    else if (stall)         ack_async = 1'b0;
    else if (ack_async != req) begin
      if (dly == 0) begin
        ack_async = req;
        dly       = $urandom_range(0, 3);
      end else dly--;
    end
  end

  // Monitor: compare every cycle against the model and pop one record per completed handshake.
  int dut_dones = 0;
  int dut_rises = 0;
  bit req_prev  = 1'b0;

  always @(negedge clka) begin
    checkOutput("req", int'(req), m_req);
    checkOutput("done_pul", int'(done_pul), m_done);
    checkOutput("pend_cnt", int'(pend_cnt), m_pend);
    checkOutput("busy", int'(busy), int'(m_phase != 0 || m_pend != 0));
    checkOutput("ovf", int'(ovf), m_ovf);
    checkOutput("timeout", int'(timeout), m_to);
    if (req && !req_prev) dut_rises++;
    req_prev = req;
    if (done_pul) begin
      dut_dones++;
      checkOutput("done_record_available", int'(done_q.size() != 0), 1);
      if (done_q.size() != 0) begin
        done_rec_t r;
        r = done_q.pop_front();
        checkOutput("done_pend_cnt", int'(pend_cnt), r.pend);
        checkOutput("done_ovf", int'(ovf), r.ovf);
      end
    end
  end

  // Peak pending depth, sampled just after each active edge.
  int dut_peak = 0;
  always @(posedge clka) begin
    #1;
    if (int'(pend_cnt) > dut_peak) dut_peak = int'(pend_cnt);
  end

  task automatic applyStimulus(input int n, input int p_pul, input int p_clr);
    for (int i = 0; i < n; i++) begin
      @(negedge clka);
      a_pul   = ($urandom_range(0, 99) < p_pul);
      err_clr = ($urandom_range(0, 99) < p_clr);
    end
    @(negedge clka);
    a_pul   = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < budget && !idle; i++) begin
      @(negedge clka);
      idle = (m_phase == 0) && (m_pend == 0);
    end
    checkOutput("drain_done", int'(idle), 1);
    repeat (2) @(negedge clka);
  endtask

  task automatic waitReq(input int budget);
    for (int i = 0; i < budget && !req; i++) @(negedge clka);
    checkOutput("req_seen", int'(req), 1);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int d0;
    int r0;
    rstna = 1'b0;
    repeat (3) @(negedge clka);
    checkOutput("reset_req", int'(req), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_pend", int'(pend_cnt), 0);
    rstna = 1'b1;

    // Single event
    d0 = dut_dones; r0 = dut_rises;
    applyStimulus(1, 100, 0);
    waitIdle(200);
    checkOutput("single_dones", dut_dones - d0, 1);
    checkOutput("single_rises", dut_rises - r0, 1);
    checkOutput("single_busy", int'(busy), 0);

    // Burst of five consecutive pulses
    d0 = dut_dones; r0 = dut_rises; dut_peak = 0;
    applyStimulus(5, 100, 0);
    waitIdle(500);
    checkOutput("burst_peak", dut_peak, 4);
    checkOutput("burst_dones", dut_dones - d0, 5);
    checkOutput("burst_rises", dut_rises - r0, 5);
    checkOutput("burst_ovf", int'(ovf), 0);

    // Random traffic
    applyStimulus(300, 30, 3);
    waitIdle(3000);

    // Saturation with ack stalled
    d0 = dut_dones;
    stall = 1'b1;
    applyStimulus(1, 100, 0);
    waitReq(20);
    applyStimulus(PEND_MAX + 2, 100, 0);
    checkOutput("sat_pend", int'(pend_cnt), PEND_MAX);
    checkOutput("sat_ovf", int'(ovf), 1);
    @(negedge clka); a_pul = 1'b1; err_clr = 1'b1;
    @(negedge clka); a_pul = 1'b0; err_clr = 1'b0;
    checkOutput("sat_set_beats_clr", int'(ovf), 1);
    @(negedge clka); err_clr = 1'b1;
    @(negedge clka); err_clr = 1'b0;
    checkOutput("sat_ovf_cleared", int'(ovf), 0);
    stall = 1'b0;
    waitIdle(2000);
    checkOutput("sat_dones", dut_dones - d0, PEND_MAX + 1);

    // Leftover/spurious ack while idle blocks launches
    force_ack = 1'b1;
    repeat (5) @(negedge clka);
    applyStimulus(2, 100, 0);
    repeat (6) @(negedge clka);
    checkOutput("spur_req", int'(req), 0);
    checkOutput("spur_pend", int'(pend_cnt), 2);
    checkOutput("spur_ovf", int'(ovf), 0);
    force_ack = 1'b0;
    waitIdle(500);

    // Reset while a transfer is stalled in flight
    stall = 1'b1;
    applyStimulus(4, 100, 0);
    checkOutput("pre_reset_pend", int'(pend_cnt), 3);
    checkOutput("pre_reset_req", int'(req), 1);
    @(posedge clka); #1;
    rstna = 1'b0;
    #1;
    checkOutput("async_reset_req", int'(req), 0);
    checkOutput("async_reset_pend", int'(pend_cnt), 0);
    checkOutput("async_reset_busy", int'(busy), 0);
    @(negedge clka);
    rstna = 1'b1;
    stall = 1'b0;
    r0 = dut_rises;
    repeat (10) @(negedge clka);
    checkOutput("post_reset_rises", dut_rises - r0, 0);

`ifdef PULSE_HS_TX_TIMEOUT_EN
    // Stalled handshake raises the sticky timeout but keeps waiting
    stall = 1'b1;
    applyStimulus(1, 100, 0);
    waitReq(20);
    repeat (TO_LIMIT + 4) @(negedge clka);
    checkOutput("to_flag", int'(timeout), 1);
    checkOutput("to_req_held", int'(req), 1);
    stall = 1'b0;
    waitIdle(500);
    checkOutput("to_sticky", int'(timeout), 1);
    @(negedge clka); err_clr = 1'b1;
    @(negedge clka); err_clr = 1'b0;
    checkOutput("to_cleared", int'(timeout), 0);
`endif

    checkOutput("req_rises_total", dut_rises, m_launches);
    checkOutput("scoreboard_empty", done_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
